pytxaclbufctrl: RTL and testbench



---
 rtl/pytxaclbufctrl.sv | 142 ++++++++++++++
 tb/tb_pytxaclbufctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pytxaclbufctrl.sv
// ACL transmit payload buffer controller.
// Two 256x32 ping-pong payload buffers: the baseband state machine fills the
// write-side buffer and commits it, and the link controller reads the oldest
// committed buffer during packet encode. A committed buffer is kept until the
// remote device ACKs a transmission of it, so NAKs and timeouts retransmit
// the same payload.

module pytxaclbufctrl (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        m_tslot_p,
  input  logic        s_tslot_p,
  input  logic        regi_isMaster,
  input  logic        pk_encode,
  input  logic        ack_p,
  input  logic        flush_p,
  input  logic [9:0]  regi_txpylenByte,
  input  logic        regi_aclbufload_p,
  input  logic [7:0]  bsm_addr,
  input  logic [31:0] bsm_din,
  input  logic        bsm_we,
  input  logic        bsm_cs,
  input  logic [7:0]  lnctrl_addr,
  input  logic        lnctrl_cs,
  output logic [31:0] lnctrl_dout,
  output logic [9:0]  enc_pylenByte,
  output logic [7:0]  enc_endaddr,
  output logic        txbuf_valid,
  output logic        regi_acltxbuffull,
  output logic        regi_acltxbufempty,
  output logic        load_ovf_p
);

  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_full;
  logic [9:0]  r_len0;
  logic [9:0]  r_len1;
  logic        r_sent;
  logic        r_loadOvf;
  logic [31:0] r_lnDout;
  logic [31:0] r_mem0 [0:255];
  logic [31:0] r_mem1 [0:255];

  logic        w_msTslot;
  logic        w_commit;
  logic        w_overflow;
  logic        w_release;
  logic        w_bsmWr;
  logic        w_lnRd;
  logic [1:0]  w_fullNext;
  logic [9:0]  w_curLen;

  assign w_msTslot  = regi_isMaster ? m_tslot_p : s_tslot_p;
  // full[wptr] is sampled before any same-cycle ack clears a buffer
  assign w_commit   = regi_aclbufload_p & ~r_full[r_wptr];
  assign w_overflow = regi_aclbufload_p &  r_full[r_wptr];
  assign w_release  = ack_p & r_sent & r_full[r_rptr];
  // A committed buffer is write-protected until it is released
  assign w_bsmWr    = bsm_cs & bsm_we & ~r_full[r_wptr];
  // When both pointers meet on an uncommitted buffer, the bsm owns it
  assign w_lnRd     = lnctrl_cs & ~((r_wptr == r_rptr) & ~r_full[r_rptr]);

  // Next commit flags: commit and release touch different buffers when both fire
  always_comb begin
    w_fullNext = r_full;
    if (w_commit)  w_fullNext[r_wptr] = 1'b1;
    if (w_release) w_fullNext[r_rptr] = 1'b0;
  end

  // Buffer pointers, commit flags, sent flag and overflow pulse
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_full    <= 2'b00;
      r_sent    <= 1'b0;
      r_loadOvf <= 1'b0;
    end else if (flush_p) begin
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_full    <= 2'b00;
      r_sent    <= 1'b0;
      r_loadOvf <= 1'b0;
    end else begin
      r_full    <= w_fullNext;
      r_loadOvf <= w_overflow;
      if (w_commit)  r_wptr <= ~r_wptr;
      if (w_release) r_rptr <= ~r_rptr;
      if (w_release)
        r_sent <= 1'b0;
      else if (w_msTslot & pk_encode & r_full[r_rptr])
        r_sent <= 1'b1;
    end
  end

  // Payload lengths latched at commit time
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_len0 <= 10'd0;
      r_len1 <= 10'd0;
    end else if (!flush_p && w_commit) begin
      if (r_wptr) r_len1 <= regi_txpylenByte;
      else        r_len0 <= regi_txpylenByte;
    end
  end

  // Buffer storage, written only by the bsm into the unprotected write buffer
  always_ff @(posedge clk_6M) begin
    if (w_bsmWr && !r_wptr) r_mem0[bsm_addr] <= bsm_din;
    if (w_bsmWr &&  r_wptr) r_mem1[bsm_addr] <= bsm_din;
  end

  // Registered read port: data belongs to the buffer selected in the request cycle
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)
      r_lnDout <= 32'd0;
    else if (w_lnRd)
      r_lnDout <= r_rptr ? r_mem1[lnctrl_addr] : r_mem0[lnctrl_addr];
  end

  assign w_curLen = r_rptr ? r_len1 : r_len0;

  // Encoder view of the pending payload, with last-word address rounded up
  always_comb begin
    enc_endaddr = 8'd0;
    if (enc_pylenByte != 10'd0) begin
      if (enc_pylenByte[1:0] == 2'b00)
        enc_endaddr = enc_pylenByte[9:2] - 8'd1;
      else
        enc_endaddr = enc_pylenByte[9:2];
    end
  end

  assign txbuf_valid        = r_full[r_rptr];
  assign enc_pylenByte      = txbuf_valid ? w_curLen : 10'd0;
  assign regi_acltxbuffull  = r_full[0] & r_full[1];
  assign regi_acltxbufempty = ~r_full[0] & ~r_full[1];
  assign load_ovf_p         = r_loadOvf;
  assign lnctrl_dout        = r_lnDout;

endmodule

// File: tb/tb_pytxaclbufctrl.sv
// Directed self-checking bench for the ACL TX payload buffer controller.
module tb_pytxaclbufctrl;

  logic        clk_6M = 1'b0;
  logic        rstz;
  logic        m_tslot_p, s_tslot_p, regi_isMaster, pk_encode;
  logic        ack_p, flush_p, regi_aclbufload_p;
  logic [9:0]  regi_txpylenByte;
  logic [7:0]  bsm_addr;
  logic [31:0] bsm_din;
  logic        bsm_we, bsm_cs;
  logic [7:0]  lnctrl_addr;
  logic        lnctrl_cs;
  logic [31:0] lnctrl_dout;
  logic [9:0]  enc_pylenByte;
  logic [7:0]  enc_endaddr;
  logic        txbuf_valid, regi_acltxbuffull, regi_acltxbufempty, load_ovf_p;

  int checks = 0;
  int errors = 0;
  logic [31:0] bufData [0:6];

  pytxaclbufctrl dut (
    .clk_6M(clk_6M), .rstz(rstz),
    .m_tslot_p(m_tslot_p), .s_tslot_p(s_tslot_p), .regi_isMaster(regi_isMaster),
    .pk_encode(pk_encode), .ack_p(ack_p), .flush_p(flush_p),
    .regi_txpylenByte(regi_txpylenByte), .regi_aclbufload_p(regi_aclbufload_p),
    .bsm_addr(bsm_addr), .bsm_din(bsm_din), .bsm_we(bsm_we), .bsm_cs(bsm_cs),
    .lnctrl_addr(lnctrl_addr), .lnctrl_cs(lnctrl_cs), .lnctrl_dout(lnctrl_dout),
    .enc_pylenByte(enc_pylenByte), .enc_endaddr(enc_endaddr),
    .txbuf_valid(txbuf_valid), .regi_acltxbuffull(regi_acltxbuffull),
    .regi_acltxbufempty(regi_acltxbufempty), .load_ovf_p(load_ovf_p)
  );

  always #83 clk_6M = ~clk_6M;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic bsmWrite(input logic [7:0] a, input logic [31:0] d);
    bsm_addr = a; bsm_din = d; bsm_cs = 1'b1; bsm_we = 1'b1;
    step();
    bsm_cs = 1'b0; bsm_we = 1'b0;
  endtask

  task automatic commit(input logic [9:0] len);
    regi_txpylenByte = len; regi_aclbufload_p = 1'b1;
    step();
    regi_aclbufload_p = 1'b0;
  endtask

  task automatic txSlot();
    m_tslot_p = 1'b1; pk_encode = 1'b1;
    step();
    m_tslot_p = 1'b0; pk_encode = 1'b0;
  endtask

  task automatic ack();
    ack_p = 1'b1;
    step();
    ack_p = 1'b0;
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    m_tslot_p = 0; s_tslot_p = 0; regi_isMaster = 1; pk_encode = 0;
    ack_p = 0; flush_p = 0; regi_aclbufload_p = 0; regi_txpylenByte = 0;
    bsm_addr = 0; bsm_din = 0; bsm_we = 0; bsm_cs = 0; lnctrl_addr = 0; lnctrl_cs = 0;
    #300;
    checks++; if (regi_acltxbufempty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %0b expected 1", regi_acltxbufempty); end
    checks++; if (txbuf_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", txbuf_valid); end
    checks++; if (enc_pylenByte !== 10'd0) begin errors++; $display("[TB] FAIL reset_pylen: got %0d expected 0", enc_pylenByte); end
    checks++; if (regi_acltxbuffull !== 1'b0 || load_ovf_p !== 1'b0 || enc_endaddr !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_misc: full=%0b ovf=%0b endaddr=%0d expected 0 0 0", regi_acltxbuffull, load_ovf_p, enc_endaddr); end
    @(negedge clk_6M);
    rstz = 1'b1;
    step();
  endtask

  task automatic test_single();
    for (int i = 0; i < 7; i++) begin
      bufData[i] = 32'hA5000000 + 32'(i * 32'h01010101);
      bsmWrite(8'(i), bufData[i]);
    end
    commit(10'd27);
    checks++; if (txbuf_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b expected 1", txbuf_valid); end
    checks++; if (enc_pylenByte !== 10'd27) begin errors++; $display("[TB] FAIL single_pylen: got %0d expected 27", enc_pylenByte); end
    checks++; if (enc_endaddr !== 8'd6) begin errors++; $display("[TB] FAIL single_endaddr: got %0d expected 6", enc_endaddr); end
    for (int i = 0; i < 7; i++) begin
      lnctrl_cs = 1'b1; lnctrl_addr = 8'(i);
      step();
      checks++; if (lnctrl_dout !== bufData[i]) begin errors++; $display("[TB] FAIL single_read%0d: got %h expected %h", i, lnctrl_dout, bufData[i]); end
    end
    lnctrl_cs = 1'b0;
    txSlot();
    ack();
    checks++; if (regi_acltxbufempty !== 1'b1 || txbuf_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release: empty=%0b valid=%0b expected 1 0", regi_acltxbufempty, txbuf_valid); end
  endtask

  task automatic test_overflow();
    flush_p = 1'b1; step(); flush_p = 1'b0;
    bsmWrite(8'd0, 32'hCAFE0001);
    commit(10'd8);
    commit(10'd17);
    checks++; if (regi_acltxbuffull !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %0b expected 1", regi_acltxbuffull); end
    checks++; if (load_ovf_p !== 1'b0) begin errors++; $display("[TB] FAIL ovf_noearly: got %0b expected 0", load_ovf_p); end
    commit(10'd33);
    checks++; if (load_ovf_p !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pulse: got %0b expected 1", load_ovf_p); end
    step();
    checks++; if (load_ovf_p !== 1'b0) begin errors++; $display("[TB] FAIL ovf_onecycle: got %0b expected 0", load_ovf_p); end
    checks++; if (enc_pylenByte !== 10'd8) begin errors++; $display("[TB] FAIL ovf_pylen0: got %0d expected 8", enc_pylenByte); end
    bsmWrite(8'd0, 32'hDEADBEEF);
    lnctrl_cs = 1'b1; lnctrl_addr = 8'd0;
    step();
    lnctrl_cs = 1'b0;
    checks++; if (lnctrl_dout !== 32'hCAFE0001) begin errors++; $display("[TB] FAIL ovf_protect: got %h expected cafe0001", lnctrl_dout); end
  endtask

  task automatic test_retransmit();
    logic [31:0] first;
    txSlot();
    lnctrl_cs = 1'b1; lnctrl_addr = 8'd0; step(); lnctrl_cs = 1'b0;
    first = lnctrl_dout;
    lnctrl_cs = 1'b1; lnctrl_addr = 8'd5; step(); lnctrl_cs = 1'b0;
    txSlot();
    lnctrl_cs = 1'b1; lnctrl_addr = 8'd0; step(); lnctrl_cs = 1'b0;
    checks++; if (lnctrl_dout !== 32'hCAFE0001 || first !== 32'hCAFE0001) begin
      errors++; $display("[TB] FAIL retx_data: got %h/%h expected cafe0001", first, lnctrl_dout); end
    checks++; if (enc_pylenByte !== 10'd8) begin errors++; $display("[TB] FAIL retx_rptr: got %0d expected 8", enc_pylenByte); end
    ack();
    checks++; if (enc_pylenByte !== 10'd17) begin errors++; $display("[TB] FAIL retx_ack: got %0d expected 17", enc_pylenByte); end
    checks++; if (enc_endaddr !== 8'd4) begin errors++; $display("[TB] FAIL retx_endaddr: got %0d expected 4", enc_endaddr); end
  endtask

  task automatic test_spurious_and_lengths();
    ack();
    checks++; if (txbuf_valid !== 1'b1 || enc_pylenByte !== 10'd17) begin
      errors++; $display("[TB] FAIL spurious_ack: valid=%0b pylen=%0d expected 1 17", txbuf_valid, enc_pylenByte); end
    // slave-slot selection must not mark a transmit while master is selected
    s_tslot_p = 1'b1; pk_encode = 1'b1; step(); s_tslot_p = 1'b0; pk_encode = 1'b0;
    ack();
    checks++; if (enc_pylenByte !== 10'd17) begin errors++; $display("[TB] FAIL slot_select: got %0d expected 17", enc_pylenByte); end
    txSlot();
    regi_txpylenByte = 10'd4; regi_aclbufload_p = 1'b1; ack_p = 1'b1;
    step();
    regi_aclbufload_p = 1'b0; ack_p = 1'b0;
    checks++; if (regi_acltxbuffull !== 1'b0 || regi_acltxbufempty !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_count: full=%0b empty=%0b expected 0 0", regi_acltxbuffull, regi_acltxbufempty); end
    checks++; if (enc_pylenByte !== 10'd4) begin errors++; $display("[TB] FAIL simul_rptr: got %0d expected 4", enc_pylenByte); end
    checks++; if (enc_endaddr !== 8'd0) begin errors++; $display("[TB] FAIL len4_endaddr: got %0d expected 0", enc_endaddr); end
    commit(10'd1023);
    checks++; if (regi_acltxbuffull !== 1'b1) begin errors++; $display("[TB] FAIL simul_wptr: got %0b expected 1", regi_acltxbuffull); end
    txSlot();
    ack();
    checks++; if (enc_pylenByte !== 10'd1023) begin errors++; $display("[TB] FAIL len1023_pylen: got %0d expected 1023", enc_pylenByte); end
    checks++; if (enc_endaddr !== 8'd255) begin errors++; $display("[TB] FAIL len1023_endaddr: got %0d expected 255", enc_endaddr); end
  endtask

  task automatic test_flush();
    commit(10'd50);
    checks++; if (regi_acltxbuffull !== 1'b1) begin errors++; $display("[TB] FAIL flush_prefull: got %0b expected 1", regi_acltxbuffull); end
    txSlot();
    flush_p = 1'b1; ack_p = 1'b1;
    step();
    flush_p = 1'b0; ack_p = 1'b0;
    checks++; if (regi_acltxbufempty !== 1'b1 || txbuf_valid !== 1'b0 || enc_pylenByte !== 10'd0) begin
      errors++; $display("[TB] FAIL flush_empty: empty=%0b valid=%0b pylen=%0d expected 1 0 0", regi_acltxbufempty, txbuf_valid, enc_pylenByte); end
    commit(10'd12);
    commit(10'd20);
    checks++; if (enc_pylenByte !== 10'd12 || regi_acltxbuffull !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_ptrs: pylen=%0d full=%0b expected 12 1", enc_pylenByte, regi_acltxbuffull); end
    // a sent flag must not survive a flush: ack after flush without a new slot is ignored
    txSlot();
    flush_p = 1'b1; step(); flush_p = 1'b0;
    commit(10'd9);
    ack();
    checks++; if (enc_pylenByte !== 10'd9) begin errors++; $display("[TB] FAIL flush_sent: got %0d expected 9", enc_pylenByte); end
  endtask

  task automatic test_midreset();
    rstz = 1'b0;
    #20;
    checks++; if (regi_acltxbufempty !== 1'b1 || enc_pylenByte !== 10'd0) begin
      errors++; $display("[TB] FAIL midreset: empty=%0b pylen=%0d expected 1 0", regi_acltxbufempty, enc_pylenByte); end
    @(negedge clk_6M);
    rstz = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_retransmit();
    test_spurious_and_lengths();
    test_flush();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
